system_ctrl: RTL
================

# system_ctrl

Parametrised successor of the system command block. It answers version/capability, time-sync, get-time, status, shutdown and clear-shutdown commands on the command/param bus. It also aggregates NFAULT fault sources into a latched shutdown with a timestamped involuntary report. It sits beside the command dispatcher and is the single owner of the global `shutdown` flag.

## Interface
- CMD_BITS, 6, width of `cmd`
- CMD_GET_VERSION / RSP_GET_VERSION, 0 / 1, command and response codes
- CMD_SYNC_TIME, 2; CMD_GET_TIME / RSP_GET_TIME, 3 / 4
- CMD_SHUTDOWN / RSP_SHUTDOWN, 5 / 6; CMD_GET_STATUS / RSP_GET_STATUS, 7 / 8; CMD_CLEAR, 9
- VERSION, 0, first version word
- NCAPS, 2, number of 32-bit capability words (1..8)
- CAPS, 0, NCAPS*32-bit vector; word k = CAPS[32k+31:32k]
- NFAULT, 8, fault source count (1..30)
- SYNC_LATENCY, 4, constant added in time sync
- clk  in  1  system clock
- rst  in  1  asynchronous, active-high reset
- systime  in  32  low system time
- time_in  in  64  full system time
- arg_data  in  32  current command argument
- arg_advance  out  1  tied to 1: one argument consumed per clock
- cmd  in  CMD_BITS  command code
- cmd_ready  in  1  command valid
- cmd_done  out  1  one-cycle completion pulse
- param_data  out  33  response word / response code
- param_write  out  1  param_data holds a response word
- invol_req / invol_grant  out / in  1  involuntary-response bus request / grant
- time_out  out  64  new system time; time_out_en  out  1  one-cycle load strobe
- timesync_latch_in  in  1  asynchronous sync pulse
- fault  in  NFAULT  level fault inputs
- shutdown  out  1  global shutdown
- fault_latched  out  NFAULT  sticky fault record

## Operation
- Reset value of every output and register is 0, including time_out, latched_time, first_fault_time and the synchronizer flops. The state machine resets to IDLE.
- States: IDLE, VER, SYNC, TIME, STAT, WGRANT, SHUT, DONE.
- Command acceptance: only in IDLE, when cmd_ready=1. Commands have priority over an involuntary report in the same cycle.
- Response stream: words are presented with param_write=1, one per cycle. The final cycle (DONE) has param_write=0, param_data=response code and cmd_done=1. The code is zero-extended; bit 32 is always 0.
- GET_VERSION sends VERSION, then CAPS words 0..NCAPS-1, then RSP_GET_VERSION.
- GET_TIME sends time_in[31:0], then the time_in[63:32] value captured at acceptance, then RSP_GET_TIME.
- GET_STATUS sends:
  - status word: bit31 = shutdown, bit30 = latched, bits[NFAULT-1:0] = fault_latched, rest 0;
  - then first_fault_time;
  - then RSP_GET_STATUS.
- SYNC_TIME: arg0 = lo (at acceptance), arg1 = hi (next cycle).
  - If latched=1: time_out = time_in − latched_time + {hi,lo} + SYNC_LATENCY (mod 2^64) and time_out_en pulses.
  - If latched=0: no time_out_en.
  - In both cases latched clears and cmd_done pulses. No param words are sent.
- SHUTDOWN: shutdown ← 1 and cmd_done pulses the next cycle. No param words are sent.
- CLEAR: if fault==0, shutdown, fault_latched and first_fault_time clear; otherwise nothing changes. cmd_done pulses either way.
- Unknown cmd: cmd_done pulses, nothing else happens.
- Timesync: timesync_latch_in passes through a 2-flop synchronizer. On a falling edge at the synchronizer output, latched_time ← time_in and latched ← 1.
  - A falling edge coinciding with the SYNC compute cycle: the computation uses the old latched_time, and latched ends at 1 (the set wins over the clear).
- Faults: while shutdown=0, fault_latched |= fault every cycle.
  - On the cycle fault_latched goes from 0 to nonzero, first_fault_time ← systime.
- Involuntary report:
  - In IDLE with fault_latched≠0, shutdown=0 and no cmd_ready: invol_req ← 1, go to WGRANT.
  - On invol_grant: invol_req ← 0 and the block sends fault_latched, then first_fault_time, then DONE with RSP_SHUTDOWN and cmd_done. shutdown ← 1 in that same DONE cycle.
  - Faults arriving during WGRANT/SHUT are still ORed in until shutdown=1.
- rst mid-operation aborts any stream immediately. All outputs go to 0 and invol_req drops.

## Timing
- E = the clock edge sampling cmd_ready=1 in IDLE. "After E+n" means the value visible after edge E+n.
- GET_VERSION: word k after E+k (k=0..NCAPS); DONE after E+NCAPS+1. Total NCAPS+2 cycles.
- GET_TIME and GET_STATUS: words after E and E+1; DONE after E+2.
- SYNC_TIME: time_out_en and cmd_done after E+1, both single-cycle.
- SHUTDOWN, CLEAR, unknown cmd: cmd_done after E.
- Fault-to-invol_req: 1 cycle from fault_latched becoming nonzero, when IDLE.
- Grant-to-first-word: 1 cycle. DONE follows 2 cycles later.
- Latch capture: 3 cycles after a falling edge of timesync_latch_in.
- cmd_done never stays high for 2 consecutive cycles. A new command may be accepted in the cycle after DONE.

## Test plan
- Reset, then GET_VERSION with VERSION=0x11, NCAPS=2, CAPS={0xBB,0xAA} → words 0x11, 0xAA, 0xBB, then code 1 with cmd_done, 4 cycles total. Assert rst mid-stream → all outputs 0 next cycle.
- Timesync falling edge with time_in=1000 (latched_time=1000). Later, SYNC_TIME lo=5000, hi=0 issued while time_in=1200 at the compute cycle → time_out=5204, one time_out_en pulse. A second SYNC_TIME without an edge → no time_out_en, cmd_done still pulses.
- fault[3] pulses 1 cycle at systime=0x100 → invol_req. Grant 5 cycles later → words 0x8, 0x100, then RSP_SHUTDOWN. shutdown=1 and no second report.
- cmd_ready=1 (GET_TIME, time_in=0x2_00000010) in the same cycle fault[0] rises → GET_TIME words 0x10, 0x2 complete first, then invol_req.
- After shutdown: CLEAR with fault[0]=1 → GET_STATUS reports 0x80000001. Drop fault, CLEAR → GET_STATUS reports 0x0 and first_fault_time 0.
- Unknown cmd 63 → cmd_done after 1 cycle, param_write stays 0.

Source files
------------

// File: rtl/system_ctrl.sv
// system_ctrl: system command responder (version, time sync, get-time, status,
// shutdown, clear) plus fault aggregation into a latched shutdown with an
// involuntary, timestamped report. Owns the global shutdown flag.
module system_ctrl #(
  parameter int unsigned CMD_BITS        = 6,
  parameter int unsigned CMD_GET_VERSION = 0,
  parameter int unsigned RSP_GET_VERSION = 1,
  parameter int unsigned CMD_SYNC_TIME   = 2,
  parameter int unsigned CMD_GET_TIME    = 3,
  parameter int unsigned RSP_GET_TIME    = 4,
  parameter int unsigned CMD_SHUTDOWN    = 5,
  parameter int unsigned RSP_SHUTDOWN    = 6,
  parameter int unsigned CMD_GET_STATUS  = 7,
  parameter int unsigned RSP_GET_STATUS  = 8,
  parameter int unsigned CMD_CLEAR       = 9,
  parameter logic [31:0] VERSION         = 32'd0,
  parameter int unsigned NCAPS           = 2,
  parameter logic [NCAPS*32-1:0] CAPS    = '0,
  parameter int unsigned NFAULT          = 8,
  parameter logic [63:0] SYNC_LATENCY    = 64'd4
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [31:0]         systime,
  input  logic [63:0]         time_in,
  input  logic [31:0]         arg_data,
  output logic                arg_advance,
  input  logic [CMD_BITS-1:0] cmd,
  input  logic                cmd_ready,
  output logic                cmd_done,
  output logic [32:0]         param_data,
  output logic                param_write,
  output logic                invol_req,
  input  logic                invol_grant,
  output logic [63:0]         time_out,
  output logic                time_out_en,
  input  logic                timesync_latch_in,
  input  logic [NFAULT-1:0]   fault,
  output logic                shutdown,
  output logic [NFAULT-1:0]   fault_latched
);

  typedef enum logic [2:0] {
    StIdle, StVer, StSync, StTime, StStat, StWgrant, StShut, StDone
  } state_e;

  state_e             state_q, state_d;
  logic [3:0]         idx_q, idx_d;
  logic [31:0]        word_q, word_d;   // GET_TIME high word or SYNC low word
  logic [32:0]        param_data_q, param_data_d;
  logic               param_write_q, param_write_d;
  logic               cmd_done_q, cmd_done_d;
  logic               invol_req_q, invol_req_d;
  logic [63:0]        time_out_q, time_out_d;
  logic               time_out_en_q, time_out_en_d;
  logic               shutdown_q, shutdown_d;
  logic [NFAULT-1:0]  fault_latched_q, fault_latched_d;
  logic [31:0]        first_fault_time_q, first_fault_time_d;
  logic               latched_q, latched_d;
  logic [63:0]        latched_time_q, latched_time_d;
  logic [2:0]         sync_q;           // [1:0] synchronizer, [2] edge-detect history

  logic               set_shutdown, do_clear, sync_clear, sync_fall;
  logic [31:0]        status_word, cap_word;

  assign sync_fall = sync_q[2] & ~sync_q[1];

  // Command / report sequencing; every output is registered from here.
  always_comb begin
    state_d       = state_q;
    idx_d         = idx_q;
    word_d        = word_q;
    param_data_d  = '0;
    param_write_d = 1'b0;
    cmd_done_d    = 1'b0;
    invol_req_d   = 1'b0;
    time_out_d    = time_out_q;
    time_out_en_d = 1'b0;
    set_shutdown  = 1'b0;
    do_clear      = 1'b0;
    sync_clear    = 1'b0;

    status_word             = '0;
    status_word[31]         = shutdown_q;
    status_word[30]         = latched_q;
    status_word[NFAULT-1:0] = fault_latched_q;
    cap_word                = 32'(CAPS >> (32 * idx_q));

    case (state_q)
      StIdle: begin
        idx_d = '0;
        if (cmd_ready) begin
          case (cmd)
            CMD_BITS'(CMD_GET_VERSION): begin
              param_data_d  = {1'b0, VERSION};
              param_write_d = 1'b1;
              state_d       = StVer;
            end
            CMD_BITS'(CMD_SYNC_TIME): begin
              word_d  = arg_data;
              state_d = StSync;
            end
            CMD_BITS'(CMD_GET_TIME): begin
              param_data_d  = {1'b0, time_in[31:0]};
              param_write_d = 1'b1;
              word_d        = time_in[63:32];
              state_d       = StTime;
            end
            CMD_BITS'(CMD_GET_STATUS): begin
              param_data_d  = {1'b0, status_word};
              param_write_d = 1'b1;
              state_d       = StStat;
            end
            CMD_BITS'(CMD_SHUTDOWN): begin
              set_shutdown = 1'b1;
              param_data_d = 33'(RSP_SHUTDOWN);
              cmd_done_d   = 1'b1;
              state_d      = StDone;
            end
            CMD_BITS'(CMD_CLEAR): begin
              do_clear   = (fault == '0);
              cmd_done_d = 1'b1;
              state_d    = StDone;
            end
            default: begin
              cmd_done_d = 1'b1;
              state_d    = StDone;
            end
          endcase
        end else if (fault_latched_q != '0 && !shutdown_q) begin
          invol_req_d = 1'b1;
          state_d     = StWgrant;
        end
      end
      StVer: begin
        if (idx_q < 4'(NCAPS)) begin
          param_data_d  = {1'b0, cap_word};
          param_write_d = 1'b1;
          idx_d         = idx_q + 4'd1;
        end else begin
          param_data_d = 33'(RSP_GET_VERSION);
          cmd_done_d   = 1'b1;
          state_d      = StDone;
        end
      end
      StSync: begin
        // arg_data now carries the high word
        if (latched_q) begin
          time_out_d    = time_in - latched_time_q + {arg_data, word_q} + SYNC_LATENCY;
          time_out_en_d = 1'b1;
        end
        sync_clear = 1'b1;
        cmd_done_d = 1'b1;
        state_d    = StDone;
      end
      StTime: begin
        if (idx_q == 4'd0) begin
          param_data_d  = {1'b0, word_q};
          param_write_d = 1'b1;
          idx_d         = 4'd1;
        end else begin
          param_data_d = 33'(RSP_GET_TIME);
          cmd_done_d   = 1'b1;
          state_d      = StDone;
        end
      end
      StStat: begin
        if (idx_q == 4'd0) begin
          param_data_d  = {1'b0, first_fault_time_q};
          param_write_d = 1'b1;
          idx_d         = 4'd1;
        end else begin
          param_data_d = 33'(RSP_GET_STATUS);
          cmd_done_d   = 1'b1;
          state_d      = StDone;
        end
      end
      StWgrant: begin
        if (invol_grant) begin
          param_data_d  = 33'(fault_latched_q);
          param_write_d = 1'b1;
          idx_d         = '0;
          state_d       = StShut;
        end else begin
          invol_req_d = 1'b1;
        end
      end
      StShut: begin
        if (idx_q == 4'd0) begin
          param_data_d  = {1'b0, first_fault_time_q};
          param_write_d = 1'b1;
          idx_d         = 4'd1;
        end else begin
          param_data_d = 33'(RSP_SHUTDOWN);
          cmd_done_d   = 1'b1;
          set_shutdown = 1'b1;
          state_d      = StDone;
        end
      end
      StDone:  state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  // Timesync latch, fault accumulation and shutdown flag bookkeeping.
  always_comb begin
    latched_d      = latched_q;
    latched_time_d = latched_time_q;
    if (sync_clear) latched_d = 1'b0;
    // A capture in the same cycle as a SYNC compute wins over the clear.
    if (sync_fall) begin
      latched_d      = 1'b1;
      latched_time_d = time_in;
    end

    shutdown_d         = shutdown_q;
    fault_latched_d    = fault_latched_q;
    first_fault_time_d = first_fault_time_q;
    if (!shutdown_q) fault_latched_d = fault_latched_q | fault;
    if (fault_latched_q == '0 && fault_latched_d != '0) first_fault_time_d = systime;
    if (set_shutdown) shutdown_d = 1'b1;
    if (do_clear) begin
      shutdown_d         = 1'b0;
      fault_latched_d    = '0;
      first_fault_time_d = '0;
    end
  end

  // State and output registers with asynchronous reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q            <= StIdle;
      idx_q              <= '0;
      word_q             <= '0;
      param_data_q       <= '0;
      param_write_q      <= 1'b0;
      cmd_done_q         <= 1'b0;
      invol_req_q        <= 1'b0;
      time_out_q         <= '0;
      time_out_en_q      <= 1'b0;
      shutdown_q         <= 1'b0;
      fault_latched_q    <= '0;
      first_fault_time_q <= '0;
      latched_q          <= 1'b0;
      latched_time_q     <= '0;
      sync_q             <= '0;
    end else begin
      state_q            <= state_d;
      idx_q              <= idx_d;
      word_q             <= word_d;
      param_data_q       <= param_data_d;
      param_write_q      <= param_write_d;
      cmd_done_q         <= cmd_done_d;
      invol_req_q        <= invol_req_d;
      time_out_q         <= time_out_d;
      time_out_en_q      <= time_out_en_d;
      shutdown_q         <= shutdown_d;
      fault_latched_q    <= fault_latched_d;
      first_fault_time_q <= first_fault_time_d;
      latched_q          <= latched_d;
      latched_time_q     <= latched_time_d;
      sync_q             <= {sync_q[1:0], timesync_latch_in};
    end
  end

  assign arg_advance   = 1'b1;
  assign cmd_done      = cmd_done_q;
  assign param_data    = param_data_q;
  assign param_write   = param_write_q;
  assign invol_req     = invol_req_q;
  assign time_out      = time_out_q;
  assign time_out_en   = time_out_en_q;
  assign shutdown      = shutdown_q;
  assign fault_latched = fault_latched_q;

endmodule
